borrow_look_ahead_subtractor_seq: RTL



---
 rtl/borrow_look_ahead_subtractor_seq_if.sv | 39 +++
 rtl/borrow_look_ahead_subtractor_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/borrow_look_ahead_subtractor_seq_if.sv
// Operand/result handshake bundle for the sequential borrow look-ahead subtractor.
// Carries ovf only when SUB_OVERFLOW_EN is defined.
interface borrow_look_ahead_subtractor_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic [WIDTH:0]   out;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, out, ovf
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, out, ovf
    );
`else
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, Bout, out
    );

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, Bout, out
    );
`endif
endinterface

// File: rtl/borrow_look_ahead_subtractor_seq.sv
// Sequential subtractor D = A - B - Bin, one 4-bit borrow look-ahead chunk per clock (K = WIDTH/4 RUN cycles).
// Optional macro SUB_OVERFLOW_EN adds a registered signed-overflow flag ovf.
module borrow_look_ahead_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input logic                                     clk,
    input logic                                     rst,
    borrow_look_ahead_subtractor_seq_if.slave       bus
);
    // WIDTH is expected to be a multiple of 4 and at least 4.
    localparam int K      = WIDTH / 4;
    localparam int STEP_W = $clog2(K) + 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              in_rdy;
    logic              out_vld;

    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  d_q;
    logic              borrow_q;
    logic              bout_q;
    logic [STEP_W-1:0] step_q;
    logic              last_step;

    logic [3:0]        ca;
    logic [3:0]        cb;
    logic [3:0]        g;
    logic [3:0]        p;
    logic [4:0]        bc;
    logic [3:0]        diff;

    assign last_step = (step_q == LAST_STEP);

    // Select the chunk addressed by the step counter.
    always_comb begin
        ca = '0;
        cb = '0;
        for (int k = 0; k < K; k++) begin
            if (step_q == STEP_W'(k)) begin
                ca = a_q[4*k +: 4];
                cb = b_q[4*k +: 4];
            end
        end
    end

    // Borrow generate when a=0,b=1; propagate when a==b; every borrow is a flat sum of products.
    always_comb begin
        g     = ~ca & cb;
        p     = ~(ca ^ cb);
        bc[0] = borrow_q;
        bc[1] = g[0]
              | (p[0] & bc[0]);
        bc[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & bc[0]);
        bc[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bc[0]);
        bc[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bc[0]);
        diff  = ca ^ cb ^ bc[3:0];
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            IDLE: begin
                in_rdy = ~rst;
                if (bus.in_valid && !rst) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // D and Bout are deliberately left untouched on accept; only RUN edges write them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            step_q   <= '0;
        end else if (accept) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= bus.Bin;
            step_q   <= '0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < K; k++) begin
                if (step_q == STEP_W'(k)) begin
                    d_q[4*k +: 4] <= diff;
                end
            end
            borrow_q <= bc[4];
            step_q   <= step_q + 1'b1;
            if (last_step) begin
                bout_q <= bc[4];
            end
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow: operands differ in sign and the result sign differs from A's.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == RUN) && last_step) begin
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[3] != a_q[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.out       = {bout_q, d_q};

endmodule
